// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte stream into
// 32-bit words, writes them to instruction memory, then releases the CPU reset.
// Optional build macro: PROG_LOADER_CHECKSUM_EN (trailing XOR checksum byte, CHK/ERROR states).
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byteValid,
  input  logic [7:0]        byteIn,
  output logic              byteReady,
  output logic              imWrite,
  output logic [ADDR_W-1:0] imAddr,
  output logic [31:0]       imData,
  output logic              cpuRst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_DONE  = 3'd4,
    S_CHK   = 3'd5,
    S_ERROR = 3'd6
`else
    S_DONE  = 3'd4
`endif
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t              state_q, state_d;
  logic [1:0]          byteCnt_q, byteCnt_d;
  logic [15:0]         wordCnt_q, wordCnt_d;
  logic [15:0]         len_q, len_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   imAddr_q, imAddr_d;
  logic [31:0]         imData_q, imData_d;
  logic                accept;
  logic                startLoad;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      byteCnt_q <= '0;
      wordCnt_q <= '0;
      len_q     <= '0;
      word_q    <= '0;
      imAddr_q  <= ADDR_W'(BASE_ADDR);
      imData_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      wordCnt_q <= wordCnt_d;
      len_q     <= len_d;
      word_q    <= word_d;
      imAddr_q  <= imAddr_d;
      imData_q  <= imData_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign byteReady = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                     || (state_q == S_CHK)
`endif
                     ;
  assign accept  = byteValid & byteReady;
  assign imWrite = (state_q == S_WRITE);
  assign busy    = byteReady || (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  // The processor runs only once a load has completed successfully.
  assign cpuRst  = (state_q != S_DONE);
  assign imAddr  = imAddr_q;
  assign imData  = imData_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  assign err     = (state_q == S_ERROR);
  assign startLoad = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
`else
  assign err     = 1'b0;
  assign startLoad = start && ((state_q == S_IDLE) || (state_q == S_DONE));
`endif

  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    wordCnt_d = wordCnt_q;
    len_d     = len_q;
    word_d    = word_q;
    imAddr_d  = imAddr_q;
    imData_d  = imData_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
    if (accept) begin
      csum_d = csum_q ^ byteIn;
    end
`endif

    if (startLoad) begin
      state_d   = S_LEN;
      byteCnt_d = '0;
      wordCnt_d = '0;
      len_d     = '0;
      imAddr_d  = ADDR_W'(BASE_ADDR);
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d    = '0;
`endif
    end else begin
      case (state_q)
        S_LEN: begin
          if (accept) begin
            if (byteCnt_q == 2'd0) begin
              len_d[7:0] = byteIn;
              byteCnt_d  = 2'd1;
            end else begin
              len_d[15:8] = byteIn;
              byteCnt_d   = 2'd0;
              state_d     = ({byteIn, len_q[7:0]} == 16'd0) ? S_FINISH : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            byteCnt_d = byteCnt_q + 2'd1;
            // The fourth byte goes straight into the write word; the first three are buffered.
            if (byteCnt_q == 2'd3) begin
              imData_d = {byteIn, word_q};
              imAddr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(wordCnt_q);
              state_d  = S_WRITE;
            end else begin
              word_d = {byteIn, word_q[23:8]};
            end
          end
        end
        S_WRITE: begin
          if (wordCnt_q + 16'd1 == len_q) begin
            state_d = S_FINISH;
          end else begin
            wordCnt_d = wordCnt_q + 16'd1;
            state_d   = S_DATA;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            state_d = (byteIn == csum_q) ? S_DONE : S_ERROR;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
`endif
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: two instances (ADDR_W=10 and ADDR_W=2) share one stream;
// a scoreboard of expected writes is filled as words are driven and drained by a write monitor.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byteValid;
  logic [7:0]  byteIn;

  logic        aReady, aWrite, aCpuRst, aBusy, aDone, aErr;
  logic [9:0]  aAddr;
  logic [31:0] aData;
  logic        bReady, bWrite, bCpuRst, bBusy, bDone, bErr;
  logic [1:0]  bAddr;
  logic [31:0] bData;

  int          vectors = 0;
  int          miscompares = 0;
  logic [41:0] qA[$];
  logic [33:0] qB[$];
  logic [7:0]  tbXor;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .byteValid(byteValid), .byteIn(byteIn),
    .byteReady(aReady), .imWrite(aWrite), .imAddr(aAddr), .imData(aData),
    .cpuRst(aCpuRst), .busy(aBusy), .done(aDone), .err(aErr)
  );

  prog_loader #(.ADDR_W(2), .BASE_ADDR(0)) dutW (
    .clk(clk), .rst(rst), .start(start), .byteValid(byteValid), .byteIn(byteIn),
    .byteReady(bReady), .imWrite(bWrite), .imAddr(bAddr), .imData(bData),
    .cpuRst(bCpuRst), .busy(bBusy), .done(bDone), .err(bErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the oldest pending scoreboard entry.
  always @(negedge clk) begin
    logic [41:0] eA;
    logic [33:0] eB;
    if (rst === 1'b1 && aWrite === 1'b1) begin
      vectors++;
      assert (qA.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL unexpectedWriteA: observed addr=0x%0h data=0x%08h expected no write", aAddr, aData);
      end
      if (qA.size() != 0) begin
        eA = qA.pop_front();
        checkOutput("imAddrA", 32'(aAddr), 32'(eA[41:32]));
        checkOutput("imDataA", aData, eA[31:0]);
        checkOutput("readyInWriteA", 32'(aReady), 32'd0);
      end
    end
    if (rst === 1'b1 && bWrite === 1'b1) begin
      vectors++;
      assert (qB.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL unexpectedWriteB: observed addr=0x%0h data=0x%08h expected no write", bAddr, bData);
      end
      if (qB.size() != 0) begin
        eB = qB.pop_front();
        checkOutput("imAddrB", 32'(bAddr), 32'(eB[33:32]));
        checkOutput("imDataB", bData, eB[31:0]);
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cpuRst"}, 32'(aCpuRst), 32'd1);
    checkOutput({tag, "_ready"},  32'(aReady),  32'd0);
    checkOutput({tag, "_write"},  32'(aWrite),  32'd0);
    checkOutput({tag, "_busy"},   32'(aBusy),   32'd0);
    checkOutput({tag, "_done"},   32'(aDone),   32'd0);
    checkOutput({tag, "_err"},    32'(aErr),    32'd0);
    checkOutput({tag, "_addr"},   32'(aAddr),   32'd0);
    checkOutput({tag, "_data"},   aData,        32'd0);
    checkOutput({tag, "_cpuRstB"}, 32'(bCpuRst), 32'd1);
  endtask

  // Drives one byte with an optional idle gap and waits (bounded) for the handshake.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    for (int i = 0; i < gap; i++) begin
      byteValid = 1'b0;
      @(negedge clk);
    end
    byteValid = 1'b1;
    byteIn    = b;
    for (int t = 0; t < 40 && !got; t++) begin
      if (aReady === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (got) tbXor = tbXor ^ b;
    vectors++;
    assert (got) else begin
      miscompares++;
      $error("[TB] FAIL byteTimeout: observed no handshake for byte 0x%02h expected accept within 40 cycles", b);
    end
  endtask

  task automatic startLoad();
    start = 1'b1;
    tbXor = 8'h00;
    @(negedge clk);
    start = 1'b0;
    checkOutput("startBusy",   32'(aBusy),   32'd1);
    checkOutput("startCpuRst", 32'(aCpuRst), 32'd1);
    checkOutput("startDone",   32'(aDone),   32'd0);
    checkOutput("startErr",    32'(aErr),    32'd0);
  endtask

  task automatic sendLen(input logic [15:0] n, input int gap);
    applyStimulus(n[7:0], gap);
    applyStimulus(n[15:8], gap);
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap, input int idx);
    qA.push_back({10'(idx), w});
    qB.push_back({2'(idx), w});
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], gap);
    checkOutput("writeLatency", 32'(aWrite), 32'd1);
  endtask

  task automatic finishStream(input bit afterWrite);
`ifdef PROG_LOADER_CHECKSUM_EN
    applyStimulus(tbXor, 0);
`else
    if (afterWrite) @(negedge clk);
`endif
    byteValid = 1'b0;
    checkOutput("doneFlag",   32'(aDone),   32'd1);
    checkOutput("doneCpuRst", 32'(aCpuRst), 32'd0);
    checkOutput("doneBusy",   32'(aBusy),   32'd0);
    checkOutput("doneErr",    32'(aErr),    32'd0);
    checkOutput("doneReady",  32'(aReady),  32'd0);
    checkOutput("doneFlagB",  32'(bDone),   32'd1);
    checkOutput("pendingA",   32'(qA.size()), 32'd0);
    checkOutput("pendingB",   32'(qB.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    byteValid = 1'b0;
    byteIn    = 8'h00;
    tbXor     = 8'h00;
    repeat (2) @(negedge clk);
    checkResetState("inReset");
    rst = 1'b1;
    @(negedge clk);
    checkResetState("idle");

    // Two words, continuous valid.
    startLoad();
    sendLen(16'd2, 0);
    sendWord(32'h20000013, 0, 0);
    sendWord(32'h00000008, 0, 1);
    finishStream(1'b1);
    checkOutput("holdData", aData, 32'h00000008);
    checkOutput("holdAddr", 32'(aAddr), 32'd1);

    // Empty program.
    startLoad();
    checkOutput("restartAddr", 32'(aAddr), 32'd0);
    sendLen(16'd0, 0);
    finishStream(1'b0);

    // Same program with valid toggling.
    startLoad();
    sendLen(16'd2, 1);
    sendWord(32'h20000013, 1, 0);
    sendWord(32'h00000008, 1, 1);
    finishStream(1'b1);

    // Five words; the ADDR_W=2 instance wraps on the fifth.
    startLoad();
    sendLen(16'd5, 0);
    for (int k = 1; k <= 5; k++) sendWord(32'h11111111 * k, 0, k - 1);
    finishStream(1'b1);
    checkOutput("wrapAddrB", 32'(bAddr), 32'd0);
    checkOutput("wrapDataB", bData, 32'h55555555);
    checkOutput("wrapAddrA", 32'(aAddr), 32'd4);

    // Reset in the middle of a word, then a clean one-word load.
    startLoad();
    sendLen(16'd1, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'hBB, 0);
    byteValid = 1'b0;
    rst = 1'b0;
    #1;
    checkResetState("midReset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("afterMidReset");
    startLoad();
    sendLen(16'd1, 0);
    sendWord(32'hDDCCBBAA, 0, 0);
    finishStream(1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good checksum.
    startLoad();
    sendLen(16'd1, 0);
    sendWord(32'h04030201, 0, 0);
    applyStimulus(8'h05, 0);
    byteValid = 1'b0;
    checkOutput("csumGoodDone",   32'(aDone),   32'd1);
    checkOutput("csumGoodErr",    32'(aErr),    32'd0);
    checkOutput("csumGoodCpuRst", 32'(aCpuRst), 32'd0);

    // Bad checksum.
    startLoad();
    sendLen(16'd1, 0);
    sendWord(32'h04030201, 0, 0);
    applyStimulus(8'h06, 0);
    byteValid = 1'b0;
    checkOutput("csumBadErr",    32'(aErr),    32'd1);
    checkOutput("csumBadCpuRst", 32'(aCpuRst), 32'd1);
    checkOutput("csumBadBusy",   32'(aBusy),   32'd0);
    checkOutput("csumBadReady",  32'(aReady),  32'd0);
    checkOutput("csumBadDone",   32'(aDone),   32'd0);

    // Restart from the error state.
    startLoad();
    sendLen(16'd0, 0);
    finishStream(1'b0);
`else
    checkOutput("errTied", 32'(aErr), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the processor's instruction memory: receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into instruction memory, then releases the processor's reset.
- Sits between the host/UART byte source and the instruction memory write port. Holds the processor in reset until the load completes.

Parameters:
- ADDR_W, 10, instruction-memory word-address width (depth 2^ADDR_W words)
- BASE_ADDR, 0, first word address written

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load from IDLE or DONE
- byteValid  input  1  source has a byte on byteIn
- byteIn  input  8  stream byte
- byteReady  output  1  loader accepts byteIn this cycle
- imWrite  output  1  instruction-memory write strobe, one cycle per word
- imAddr  output  ADDR_W  word address for imWrite
- imData  output  32  word for imWrite
- cpuRst  output  1  active-high processor reset (drives processor rst)
- busy  output  1  load in progress
- done  output  1  load completed, processor released
- err  output  1  load failed (CHECKSUM_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async) values:
  - State IDLE.
  - cpuRst=1; byteReady=0, imWrite=0, busy=0, done=0, err=0.
  - imAddr=BASE_ADDR, imData=0.
  - Internal byte counter, word counter and length register all 0.
  - Reset mid-load aborts immediately; no further imWrite.
- Byte transfer occurs only when byteValid&byteReady at a rising edge. byteIn must be stable while byteValid=1 and byteReady=0.
- Stream format:
  - LEN_LO, then LEN_HI: 16-bit word count N.
  - Then N words, 4 bytes each, LSB first.
  - With CHECKSUM_EN, one trailing checksum byte follows.
- FSM:
  - IDLE: byteReady=0, cpuRst=1. On start go to LEN; busy=1 from next cycle.
  - LEN: byteReady=1. Capture 2 bytes. After the 2nd: if N=0 go to CHK (macro on) or DONE; else go to DATA.
  - DATA: byteReady=1. Shift bytes into the word assembler, byte k into bits [8k+7:8k]. After the 4th byte go to WRITE.
  - WRITE (1 cycle):
    - byteReady=0, imWrite=1.
    - imData=assembled word; imAddr=BASE_ADDR+wordIndex, modulo 2^ADDR_W, so it wraps for N>2^ADDR_W.
    - Next cycle: if wordIndex+1==N go to CHK/DONE, else go to DATA with wordIndex incremented.
  - DONE: busy=0, done=1, cpuRst=0, byteReady=0. A start pulse reasserts cpuRst=1, clears done, and goes to LEN with imAddr back at BASE_ADDR.
- start is ignored while busy=1.
- Latency: the imWrite cycle immediately follows the cycle that accepted a word's 4th byte. cpuRst falls on the cycle after the last imWrite (N>0), or the cycle after LEN_HI is accepted (N=0, macro off).
- Minimum throughput: 4 bytes per 5 cycles in DATA.
- imData/imAddr hold their last values outside WRITE.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro:
  - Loader keeps a running XOR of every accepted byte, including the length bytes.
  - Extra state CHK (byteReady=1) accepts one byte. If byte == running XOR, go to DONE. Otherwise go to ERROR: err=1, busy=0, cpuRst stays 1, byteReady=0.
  - start from ERROR clears err and goes to LEN.
- Without the macro: no CHK/ERROR states, err tied 0, and the stream has no trailing byte.

Test Plan:
- Stream 02 00 | 13 00 00 20 | 08 00 00 00 with byteValid always 1, BASE_ADDR=0 -> imWrite at addr 0 data 0x20000013, then addr 1 data 0x00000008; done=1, cpuRst=0 on the following cycle.
- Stream 00 00 -> no imWrite pulses; DONE reached with cpuRst=0.
- Same two-word stream with byteValid toggling every other cycle -> identical writes, byteReady=0 during each WRITE cycle, no byte lost or duplicated.
- ADDR_W=2, N=5 words of value 0x11111111·k -> 5th write at imAddr 0 (wrap), data 0x55555555.
- Assert rst=0 after the 2nd data byte, then release and start again with the one-word stream AABBCCDD -> single write of 0xDDCCBBAA at addr 0; no earlier partial write.
- With PROG_LOADER_CHECKSUM_EN: stream 01 00 01 02 03 04 + checksum 0x05 -> DONE, err=0. Checksum 0x06 -> err=1, cpuRst=1; a later start clears err.
